gfx256_fragment: RTL and testbench

//  Fragment stage directly downstream of the clip/z-test stage. Accepts one surviving pixel
//  per write pulse, optionally replaces its flat color by a texel fetched from a 256-bit

---
 rtl/gfx256_fragment.sv | 186 ++++++++++++++++++
 tb/tb_gfx256_fragment.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx256_fragment.sv
// Fragment stage: optional clamped texel fetch from a 256-bit texture memory,
// color-key discard, and hand-off of the surviving pixel to the blender.
module gfx256_fragment #(
    parameter int point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   texture_enable_i,
    input  logic                   colorkey_enable_i,
    input  logic [31:0]            colorkey_i,
    input  logic [1:0]             color_depth_i,
    input  logic [31:0]            tex0_base_i,
    input  logic [point_width-1:0] tex0_size_x_i,
    input  logic [point_width-1:0] tex0_size_y_i,
    input  logic [point_width-1:0] pixel_x_i,
    input  logic [point_width-1:0] pixel_y_i,
    input  logic [point_width-1:0] pixel_z_i,
    input  logic [point_width-1:0] u_i,
    input  logic [point_width-1:0] v_i,
    input  logic [7:0]             a_i,
    input  logic [31:0]            color_i,
    input  logic                   write_i,
    output logic                   ack_o,
    output logic [31:0]            texture_addr_o,
    output logic                   texture_request_o,
    input  logic                   texture_ack_i,
    input  logic [255:0]           texture_data_i,
    input  logic                   wbm_busy_i,
    output logic [point_width-1:0] pixel_x_o,
    output logic [point_width-1:0] pixel_y_o,
    output logic [point_width-1:0] pixel_z_o,
    output logic [7:0]             a_o,
    output logic [31:0]            color_o,
    output logic                   write_o,
    input  logic                   ack_i
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR1    = 3'd1;
    localparam logic [2:0] ADDR2    = 3'd2;
    localparam logic [2:0] TEX_WAIT = 3'd3;
    localparam logic [2:0] WRITE    = 3'd4;

    logic [2:0]             state;
    logic [point_width-1:0] u_q;
    logic [point_width-1:0] v_q;
    logic [point_width-1:0] sx_q;
    logic [point_width-1:0] sy_q;
    logic [31:0]            base_q;
    logic [1:0]             depth_q;
    logic                   cke_q;
    logic [31:0]            key_q;
    logic [31:0]            idx_q;
    logic [4:0]             lane_q;

    logic [point_width-1:0] sx_m1;
    logic [point_width-1:0] sy_m1;
    logic [point_width-1:0] uc;
    logic [point_width-1:0] vc;
    logic [31:0]            idx_n;
    logic [31:0]            boff;
    logic [255:0]           shifted;
    logic [31:0]            texel;
    logic [31:0]            key_m;

    always_comb begin
        sx_m1 = sx_q - 1'b1;
        sy_m1 = sy_q - 1'b1;
        uc    = (u_q > sx_m1) ? sx_m1 : u_q;
        vc    = (v_q > sy_m1) ? sy_m1 : v_q;
        idx_n = 32'(vc) * 32'(sx_q) + 32'(uc);
    end

    // Byte offset scales with bytes per texel; depth 11 behaves as 32bpp.
    always_comb begin
        case (depth_q)
            2'b00:   boff = idx_q;
            2'b01:   boff = {idx_q[30:0], 1'b0};
            default: boff = {idx_q[29:0], 2'b00};
        endcase
    end

    always_comb begin
        shifted = texture_data_i >> {lane_q, 3'b000};
        case (depth_q)
            2'b00: begin
                texel = {24'd0, shifted[7:0]};
                key_m = {24'd0, key_q[7:0]};
            end
            2'b01: begin
                texel = {16'd0, shifted[15:0]};
                key_m = {16'd0, key_q[15:0]};
            end
            default: begin
                texel = shifted[31:0];
                key_m = key_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state             <= IDLE;
            ack_o             <= 1'b0;
            write_o           <= 1'b0;
            texture_request_o <= 1'b0;
            texture_addr_o    <= '0;
            pixel_x_o         <= '0;
            pixel_y_o         <= '0;
            pixel_z_o         <= '0;
            a_o               <= '0;
            color_o           <= '0;
            u_q               <= '0;
            v_q               <= '0;
            sx_q              <= '0;
            sy_q              <= '0;
            base_q            <= '0;
            depth_q           <= '0;
            cke_q             <= 1'b0;
            key_q             <= '0;
            idx_q             <= '0;
            lane_q            <= '0;
        end else begin
            ack_o   <= 1'b0;
            write_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_i) begin
                        pixel_x_o <= pixel_x_i;
                        pixel_y_o <= pixel_y_i;
                        pixel_z_o <= pixel_z_i;
                        a_o       <= a_i;
                        u_q       <= u_i;
                        v_q       <= v_i;
                        sx_q      <= tex0_size_x_i;
                        sy_q      <= tex0_size_y_i;
                        base_q    <= tex0_base_i;
                        depth_q   <= color_depth_i;
                        cke_q     <= colorkey_enable_i;
                        key_q     <= colorkey_i;
                        if (texture_enable_i) begin
                            state <= ADDR1;
                        end else begin
                            color_o <= color_i;
                            write_o <= 1'b1;
                            state   <= WRITE;
                        end
                    end
                end
                ADDR1: begin
                    idx_q <= idx_n;
                    state <= ADDR2;
                end
                ADDR2: begin
                    texture_addr_o <= base_q + {boff[31:5], 5'b00000};
                    lane_q         <= boff[4:0];
                    state          <= TEX_WAIT;
                end
                TEX_WAIT: begin
                    // Busy only gates raising the request, never withdraws it.
                    if (!texture_request_o) begin
                        if (!wbm_busy_i) texture_request_o <= 1'b1;
                    end else if (texture_ack_i) begin
                        texture_request_o <= 1'b0;
                        if (cke_q && texel == key_m) begin
                            ack_o <= 1'b1;
                            state <= IDLE;
                        end else begin
                            color_o <= texel;
                            write_o <= 1'b1;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (ack_i) begin
                        ack_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx256_fragment.sv
// Directed self-checking bench for gfx256_fragment.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_gfx256_fragment;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         texture_enable_i;
    logic         colorkey_enable_i;
    logic [31:0]  colorkey_i;
    logic [1:0]   color_depth_i;
    logic [31:0]  tex0_base_i;
    logic [15:0]  tex0_size_x_i;
    logic [15:0]  tex0_size_y_i;
    logic [15:0]  pixel_x_i;
    logic [15:0]  pixel_y_i;
    logic [15:0]  pixel_z_i;
    logic [15:0]  u_i;
    logic [15:0]  v_i;
    logic [7:0]   a_i;
    logic [31:0]  color_i;
    logic         write_i;
    logic         ack_o;
    logic [31:0]  texture_addr_o;
    logic         texture_request_o;
    logic         texture_ack_i;
    logic [255:0] texture_data_i;
    logic         wbm_busy_i;
    logic [15:0]  pixel_x_o;
    logic [15:0]  pixel_y_o;
    logic [15:0]  pixel_z_o;
    logic [7:0]   a_o;
    logic [31:0]  color_o;
    logic         write_o;
    logic         ack_i;

    int tests = 0;
    int fails = 0;

    gfx256_fragment #(.point_width(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .texture_enable_i(texture_enable_i),
        .colorkey_enable_i(colorkey_enable_i),
        .colorkey_i(colorkey_i), .color_depth_i(color_depth_i),
        .tex0_base_i(tex0_base_i),
        .tex0_size_x_i(tex0_size_x_i), .tex0_size_y_i(tex0_size_y_i),
        .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
        .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i),
        .write_i(write_i), .ack_o(ack_o),
        .texture_addr_o(texture_addr_o),
        .texture_request_o(texture_request_o),
        .texture_ack_i(texture_ack_i), .texture_data_i(texture_data_i),
        .wbm_busy_i(wbm_busy_i),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
        .a_o(a_o), .color_o(color_o), .write_o(write_o), .ack_i(ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        texture_enable_i = 1'b0;
        colorkey_enable_i = 1'b0;
        colorkey_i = '0;
        color_depth_i = 2'b10;
        tex0_base_i = '0;
        tex0_size_x_i = 16'd1;
        tex0_size_y_i = 16'd1;
        pixel_x_i = '0;
        pixel_y_i = '0;
        pixel_z_i = '0;
        u_i = '0;
        v_i = '0;
        a_i = '0;
        color_i = '0;
        write_i = 1'b0;
        texture_ack_i = 1'b0;
        texture_data_i = '0;
        wbm_busy_i = 1'b0;
        ack_i = 1'b0;
        tick();
        tick();
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_write", 32'(write_o), 32'd0);
        chk("rst_req", 32'(texture_request_o), 32'd0);
        chk("rst_color", color_o, 32'd0);
        chk("rst_addr", texture_addr_o, 32'd0);
        rst_i = 1'b0;
        tick();

        // 1: flat color, plus ack_i/write_i collision in WRITE
        color_i = 32'h00AABBCC;
        pixel_x_i = 16'd17;
        pixel_y_i = 16'd42;
        pixel_z_i = 16'h7FFF;
        a_i = 8'hC3;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        chk("t1_write", 32'(write_o), 32'd1);
        chk("t1_color", color_o, 32'h00AABBCC);
        chk("t1_xy", {pixel_x_o, pixel_y_o}, {16'd17, 16'd42});
        chk("t1_za", {8'd0, pixel_z_o, a_o}, {8'd0, 16'h7FFF, 8'hC3});
        tick();
        chk("t1_write_1cyc", 32'(write_o), 32'd0);
        chk("t1_no_ack", 32'(ack_o), 32'd0);
        color_i = 32'h11111111;
        write_i = 1'b1;
        ack_i = 1'b1;
        tick();
        write_i = 1'b0;
        ack_i = 1'b0;
        chk("t1_ack", 32'(ack_o), 32'd1);
        chk("t1_coll_nowrite", 32'(write_o), 32'd0);
        tick();
        chk("t1_ack_pulse", 32'(ack_o), 32'd0);
        chk("t1_coll_ignored", 32'(write_o), 32'd0);
        chk("t1_color_kept", color_o, 32'h00AABBCC);

        // 2: 32bpp, idx=73, boff=0x124 -> addr 0x1120, lane 4
        texture_enable_i = 1'b1;
        color_depth_i = 2'b10;
        tex0_base_i = 32'h1000;
        tex0_size_x_i = 16'd64;
        tex0_size_y_i = 16'd64;
        u_i = 16'd9;
        v_i = 16'd1;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        chk("t2_no_write", 32'(write_o), 32'd0);
        tick();
        tick();
        chk("t2_addr", texture_addr_o, 32'h1120);
        chk("t2_req_low", 32'(texture_request_o), 32'd0);
        tick();
        chk("t2_req", 32'(texture_request_o), 32'd1);
        texture_data_i = '0;
        texture_data_i[31:0] = 32'hDEADBEEF;
        texture_data_i[63:32] = 32'h12345678;
        texture_ack_i = 1'b1;
        tick();
        texture_ack_i = 1'b0;
        chk("t2_req_drop", 32'(texture_request_o), 32'd0);
        chk("t2_write", 32'(write_o), 32'd1);
        chk("t2_color", color_o, 32'h12345678);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t2_ack", 32'(ack_o), 32'd1);

        // 3: 16bpp clamp u=20->7, v=3 -> idx 31, boff 62, lane 30
        color_depth_i = 2'b01;
        tex0_base_i = 32'h2000;
        tex0_size_x_i = 16'd8;
        tex0_size_y_i = 16'd8;
        u_i = 16'd20;
        v_i = 16'd3;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        tick();
        tick();
        chk("t3_addr", texture_addr_o, 32'h2020);
        tick();
        texture_data_i = '0;
        texture_data_i[255:240] = 16'hBEEF;
        texture_data_i[239:224] = 16'h1111;
        texture_ack_i = 1'b1;
        tick();
        texture_ack_i = 1'b0;
        chk("t3_color", color_o, 32'h0000BEEF);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;

        // 4: 8bpp colorkey on low byte, lane 3
        color_depth_i = 2'b00;
        colorkey_enable_i = 1'b1;
        colorkey_i = 32'hFFFFFF55;
        tex0_base_i = 32'h3000;
        tex0_size_x_i = 16'd16;
        tex0_size_y_i = 16'd16;
        u_i = 16'd3;
        v_i = 16'd0;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        tick();
        tick();
        chk("t4_addr", texture_addr_o, 32'h3000);
        tick();
        texture_data_i = '0;
        texture_data_i[31:0] = 32'h55AA33CC;
        texture_ack_i = 1'b1;
        tick();
        texture_ack_i = 1'b0;
        chk("t4_key_ack", 32'(ack_o), 32'd1);
        chk("t4_key_nowrite", 32'(write_o), 32'd0);
        tick();
        chk("t4_key_ack_pulse", 32'(ack_o), 32'd0);
        chk("t4_key_nowrite2", 32'(write_o), 32'd0);
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        tick();
        tick();
        tick();
        texture_data_i[31:0] = 32'h56AA33CC;
        texture_ack_i = 1'b1;
        tick();
        texture_ack_i = 1'b0;
        chk("t4_pass_write", 32'(write_o), 32'd1);
        chk("t4_pass_color", color_o, 32'h00000056);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        colorkey_enable_i = 1'b0;

        // 5: busy holds off the request, then cannot withdraw it
        color_depth_i = 2'b10;
        tex0_base_i = 32'h4000;
        tex0_size_x_i = 16'd1;
        tex0_size_y_i = 16'd1;
        u_i = 16'd5;
        v_i = 16'd5;
        wbm_busy_i = 1'b1;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        tick();
        tick();
        chk("t5_addr", texture_addr_o, 32'h4000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_req_busy", 32'(texture_request_o), 32'd0);
        end
        wbm_busy_i = 1'b0;
        tick();
        chk("t5_req_rise", 32'(texture_request_o), 32'd1);
        wbm_busy_i = 1'b1;
        tick();
        tick();
        chk("t5_req_held", 32'(texture_request_o), 32'd1);
        texture_data_i = '0;
        texture_data_i[31:0] = 32'hCAFEF00D;
        texture_ack_i = 1'b1;
        tick();
        texture_ack_i = 1'b0;
        wbm_busy_i = 1'b0;
        chk("t5_req_drop", 32'(texture_request_o), 32'd0);
        chk("t5_color", color_o, 32'hCAFEF00D);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;

        // 6: reset while the request is outstanding
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_req_up", 32'(texture_request_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_req_rst", 32'(texture_request_o), 32'd0);
        chk("t6_ack_rst", 32'(ack_o), 32'd0);
        chk("t6_write_rst", 32'(write_o), 32'd0);
        chk("t6_addr_rst", texture_addr_o, 32'd0);
        texture_ack_i = 1'b1;
        tick();
        texture_ack_i = 1'b0;
        chk("t6_stray_ack", 32'({ack_o, write_o}), 32'd0);
        texture_enable_i = 1'b0;
        color_i = 32'h0BADCAFE;
        write_i = 1'b1;
        tick();
        write_i = 1'b0;
        chk("t6_after_write", 32'(write_o), 32'd1);
        chk("t6_after_color", color_o, 32'h0BADCAFE);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("t6_after_ack", 32'(ack_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
